// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-fed 8N1/8N2 serialiser.
// Bit timing comes from brclk rising edges sampled on sysclk.
module uart_transmitter #(
  parameter int DEPTH      = 4,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       brclk,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       TX_BUSY,
  output logic       TX_OVERRUN,
  output logic       UART_TX
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(STOP_BITS * OVERSAMPLE + 1);

  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          brclk_q;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;
  logic [7:0]    mem_q [DEPTH];

  logic tick;
  logic full;
  logic push;
  logic pop;

  assign tick = brclk & ~brclk_q;
  assign full = (count_q == FULL);
  assign push = TX_EN & ~full;

  assign TX_STATUS  = ~full;
  assign TX_BUSY    = busy_q;
  assign TX_OVERRUN = ovr_q;
  assign UART_TX    = tx_q;

  // Frame sequencer: advances only on brclk ticks, pops the FIFO head.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            cnt_d   = '0;
            state_d = START;
          end
        end
        START: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            bit_d   = '0;
            tx_d    = shift_q[0];
            state_d = DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (bit_q == 3'd7) begin
              tx_d    = 1'b1;
              state_d = STOP;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = {1'b0, shift_q[7:1]};
              tx_d    = shift_q[1];
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == STOP_LAST) begin
            cnt_d = '0;
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO bookkeeping, sticky overrun and busy flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    ovr_d    = ovr_q | (TX_EN & full);
    busy_d   = (state_d != IDLE) | (count_d != '0);
  end

  // FIFO storage; contents are don't-care until counted valid.
  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= TX_DATA;
  end

  // State registers; reset forces the line idle and empties the FIFO.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      brclk_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      brclk_q  <= brclk;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed bench with a line-decoding receiver.
// dut_a: DEPTH 4, OVERSAMPLE 16, 1 stop; dut_b: OVERSAMPLE 8, 2 stop.
module tb_uart_transmitter;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b1;
  logic       brclk  = 1'b0;
  logic       br_en  = 1'b1;
  logic [1:0] div    = 2'd0;
  logic       br_pos = 1'b0;
  int         tick_no = 0;

  logic [7:0] data_a = 8'h00;
  logic [7:0] data_b = 8'h00;
  logic       en_a   = 1'b0;
  logic       en_b   = 1'b0;
  logic       stat_a, busy_a, ovr_a, tx_a;
  logic       stat_b, busy_b, ovr_b, tx_b;

  int checks = 0;
  int errors = 0;

  int         st_a[$];
  int         st_b[$];
  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  logic [7:0] vec[$];

  uart_transmitter #(
    .DEPTH(4), .OVERSAMPLE(16), .STOP_BITS(1)
  ) dut_a (
    .sysclk(sysclk), .reset(rst), .brclk(brclk),
    .TX_DATA(data_a), .TX_EN(en_a),
    .TX_STATUS(stat_a), .TX_BUSY(busy_a),
    .TX_OVERRUN(ovr_a), .UART_TX(tx_a)
  );

  uart_transmitter #(
    .DEPTH(4), .OVERSAMPLE(8), .STOP_BITS(2)
  ) dut_b (
    .sysclk(sysclk), .reset(rst), .brclk(brclk),
    .TX_DATA(data_b), .TX_EN(en_b),
    .TX_STATUS(stat_b), .TX_BUSY(busy_b),
    .TX_OVERRUN(ovr_b), .UART_TX(tx_b)
  );

  always #5 sysclk = ~sysclk;

  // brclk: period of 4 sysclk cycles, freezable
  always @(negedge sysclk) begin
    if (br_en) begin
      div   <= div + 2'd1;
      brclk <= (div == 2'd1) || (div == 2'd2);
    end
  end

  // tick counter as seen by the design
  always @(posedge sysclk) begin
    br_pos <= brclk;
    if (brclk && !br_pos) tick_no <= tick_no + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel == 1) ? tx_b : tx_a;
  endfunction

  function automatic int qsize(input int kind);
    case (kind)
      0: return rx_a.size();
      1: return rx_b.size();
      2: return st_a.size();
      default: return st_b.size();
    endcase
  endfunction

  task automatic wait_tick(input int target);
    int n;
    n = 0;
    while (tick_no < target && n < 20000) begin
      @(negedge sysclk);
      n++;
    end
    if (tick_no < target) chk("wait_tick_timeout", tick_no, target);
  endtask

  task automatic wait_cnt(input int kind, input int want);
    int n;
    n = 0;
    while (qsize(kind) < want && n < 20000) begin
      @(negedge sysclk);
      n++;
    end
    if (qsize(kind) < want) chk("wait_cnt_timeout", qsize(kind), want);
  endtask

  task automatic push_burst(input int sel);
    foreach (vec[i]) begin
      @(negedge sysclk);
      if (sel == 1) begin
        en_b   = 1'b1;
        data_b = vec[i];
      end else begin
        en_a   = 1'b1;
        data_a = vec[i];
      end
    end
    @(negedge sysclk);
    en_a = 1'b0;
    en_b = 1'b0;
  endtask

  task automatic rx_wait(input int target, output bit ok);
    ok = 1'b1;
    while (tick_no < target) begin
      @(negedge sysclk);
      if (rst) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic rx_run(input int sel);
    int         os;
    int         st;
    int         nstop;
    logic [7:0] b;
    bit         ok;
    os    = (sel == 1) ? 8 : 16;
    nstop = (sel == 1) ? 2 : 1;
    b     = 8'h00;
    @(negedge sysclk);
    if (rst || line(sel) !== 1'b0) return;
    st = tick_no;
    if (sel == 1) st_b.push_back(st);
    else st_a.push_back(st);
    rx_wait(st + os / 2, ok);
    if (!ok) return;
    chk((sel == 1) ? "start_b" : "start_a", line(sel), 0);
    for (int k = 0; k < 8; k++) begin
      rx_wait(st + os * (k + 1) + os / 2, ok);
      if (!ok) return;
      b[k] = line(sel);
    end
    for (int s = 0; s < nstop; s++) begin
      rx_wait(st + os * (9 + s) + os / 2, ok);
      if (!ok) return;
      chk((sel == 1) ? "stop_b" : "stop_a", line(sel), 1);
    end
    if (sel == 1) rx_b.push_back(b);
    else rx_a.push_back(b);
  endtask

  initial forever rx_run(0);
  initial forever rx_run(1);

  initial begin
    int t, s, r, n, sb, rb;

    repeat (3) @(negedge sysclk);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_status_a", stat_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_ovr_a", ovr_a, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_status_b", stat_b, 1);
    chk("rst_ovr_b", ovr_b, 0);
    rst = 1'b0;
    repeat (5) @(negedge sysclk);

    // single byte
    vec = {8'h55};
    push_burst(0);
    t = tick_no;
    chk("s1_busy", busy_a, 1);
    chk("s1_status", stat_a, 1);
    wait_cnt(0, 1);
    chk("s1_start_tick", st_a[0], t + 1);
    chk("s1_data", rx_a[0], 8'h55);
    wait_tick(st_a[0] + 159);
    chk("s1_busy_stop", busy_a, 1);
    wait_tick(st_a[0] + 160);
    chk("s1_busy_end", busy_a, 0);
    chk("s1_status_end", stat_a, 1);

    // back-to-back
    sb = st_a.size();
    rb = rx_a.size();
    vec = {8'h41, 8'h42, 8'h43};
    push_burst(0);
    wait_cnt(0, rb + 3);
    chk("s2_d0", rx_a[rb], 8'h41);
    chk("s2_d1", rx_a[rb + 1], 8'h42);
    chk("s2_d2", rx_a[rb + 2], 8'h43);
    chk("s2_gap01", st_a[sb + 1] - st_a[sb], 160);
    chk("s2_gap12", st_a[sb + 2] - st_a[sb + 1], 160);
    wait_tick(st_a[sb + 2] + 160);
    chk("s2_idle", busy_a, 0);

    // overflow with brclk frozen
    br_en = 1'b0;
    repeat (2) @(negedge sysclk);
    sb = st_a.size();
    rb = rx_a.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      if (i == 4) chk("s3_full", stat_a, 0);
      en_a   = 1'b1;
      data_a = 8'h10 + 8'(i);
    end
    @(negedge sysclk);
    en_a = 1'b0;
    chk("s3_ovr", ovr_a, 1);
    chk("s3_status", stat_a, 0);
    chk("s3_busy", busy_a, 1);
    repeat (50) @(negedge sysclk);
    chk("s3_hold_tx", tx_a, 1);
    chk("s3_hold_start", st_a.size(), sb);
    br_en = 1'b1;
    wait_cnt(0, rb + 4);
    for (int i = 0; i < 4; i++) begin
      chk("s3_data", rx_a[rb + i], 8'h10 + 8'(i));
    end
    wait_tick(st_a[sb + 3] + 160);
    chk("s3_idle", busy_a, 0);
    wait_tick(tick_no + 200);
    chk("s3_count", rx_a.size(), rb + 4);
    chk("s3_ovr_sticky", ovr_a, 1);

    // push in the tick cycle
    sb = st_a.size();
    rb = rx_a.size();
    n = 0;
    do begin
      @(negedge sysclk);
      #1;
      n++;
    end while (!(brclk && !br_pos) && n < 100);
    en_a   = 1'b1;
    data_a = 8'hA5;
    @(negedge sysclk);
    en_a = 1'b0;
    t = tick_no;
    wait_cnt(0, rb + 1);
    chk("s4_start_tick", st_a[sb], t + 1);
    chk("s4_data", rx_a[rb], 8'hA5);
    wait_tick(st_a[sb] + 160);

    // reset mid-frame
    sb = st_a.size();
    rb = rx_a.size();
    vec = {8'hFF, 8'h01, 8'h02};
    push_burst(0);
    t = tick_no;
    wait_tick(t + 2);
    chk("s5_started", st_a.size(), sb + 1);
    s = st_a[sb];
    wait_tick(s + 72);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_tx", tx_a, 1);
    chk("s5_busy", busy_a, 0);
    chk("s5_status", stat_a, 1);
    chk("s5_ovr", ovr_a, 0);
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    wait_tick(tick_no + 400);
    chk("s5_no_frame", st_a.size(), sb + 1);
    chk("s5_no_byte", rx_a.size(), rb);
    chk("s5_idle_busy", busy_a, 0);
    chk("s5_idle_tx", tx_a, 1);
    vec = {8'h3C};
    push_burst(0);
    t = tick_no;
    wait_cnt(0, rb + 1);
    chk("s5_restart_tick", st_a[sb + 1], t + 1);
    chk("s5_restart_data", rx_a[rb], 8'h3C);
    wait_tick(st_a[sb + 1] + 160);
    vec = {8'h00};
    push_burst(0);
    t = tick_no;
    wait_tick(t + 2);
    chk("s5_startbit", tx_a, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_tx_async", tx_a, 1);
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (10) @(negedge sysclk);

    // two stop bits, oversample 8
    sb = st_b.size();
    rb = rx_b.size();
    vec = {8'h00, 8'hFF};
    push_burst(1);
    wait_cnt(3, sb + 1);
    n = 0;
    while (tx_b !== 1'b1 && n < 2000) begin
      @(negedge sysclk);
      n++;
    end
    r = tick_no;
    wait_cnt(1, rb + 2);
    chk("s6_d0", rx_b[rb], 8'h00);
    chk("s6_d1", rx_b[rb + 1], 8'hFF);
    chk("s6_rise", r - st_b[sb], 72);
    chk("s6_stop_len", st_b[sb + 1] - r, 16);
    chk("s6_frame", st_b[sb + 1] - st_b[sb], 88);
    wait_tick(st_b[sb + 1] + 87);
    chk("s6_busy_stop", busy_b, 1);
    wait_tick(st_b[sb + 1] + 88);
    chk("s6_busy_end", busy_b, 0);
    chk("s6_tx_idle", tx_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- UART transmit engine that pairs with the existing UART receiver and shares the same UART_Baud_Rate_Generator brclk.
- The CPU peripheral bus pushes bytes into a small FIFO. The block serialises each byte as 8N1 (or 8N2) frames on UART_TX, LSB first.
- Timing comes from rising edges of brclk, detected in the sysclk domain. OVERSAMPLE brclk ticks make one bit time.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
OVERSAMPLE, 16, brclk ticks per bit
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
sysclk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
brclk  in  1  baud-rate generator output; sampled on sysclk, and each rising edge is one tick
TX_DATA  in  8  byte to transmit
TX_EN  in  1  one-cycle write strobe; pushes TX_DATA when TX_STATUS=1
TX_STATUS  out  1  1 when FIFO not full (write will be accepted)
TX_BUSY  out  1  1 while a frame is on the line or the FIFO is non-empty
TX_OVERRUN  out  1  sticky; set by a write while full; cleared only by reset
UART_TX  out  1  serial line; idles high

Behaviour:
- Reset (async) values:
  - UART_TX=1, TX_STATUS=1, TX_BUSY=0, TX_OVERRUN=0.
  - FIFO count=0, pointers=0, FSM=IDLE, tick counter=0, bit index=0, brclk_d=0.
- Tick detection:
  - tick = brclk & ~brclk_d; brclk_d is registered each sysclk.
  - A tick lasts exactly one sysclk cycle.
- FIFO:
  - Push on TX_EN & TX_STATUS. TX_STATUS is derived from the registered count, before any same-cycle pop.
  - TX_EN while full: data dropped, TX_OVERRUN<=1. This holds even if a pop happens the same cycle.
  - Push and pop in the same cycle with count<DEPTH: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP. The tick counter counts 0..OVERSAMPLE-1 and advances only on tick.
- IDLE:
  - UART_TX=1.
  - On a tick with registered count>0: pop head into shift register, UART_TX<=0, tick counter<=0, go START.
  - A byte pushed in the same cycle as that tick while the FIFO is empty is not popped until the next tick.
- START: after OVERSAMPLE ticks, UART_TX<=shift[0], bit index<=0, go DATA.
- DATA:
  - Every OVERSAMPLE ticks, shift right and drive the next bit.
  - After bit 7 completes its OVERSAMPLE ticks: UART_TX<=1, go STOP.
- STOP: lasts STOP_BITS*OVERSAMPLE ticks. At its end:
  - If count>0: pop immediately, UART_TX<=0, go START. Back-to-back frames have no idle gap.
  - Else go IDLE.
- Line timing:
  - UART_TX changes only in the sysclk cycle after a tick edge.
  - Frame length = (10 or 11)*OVERSAMPLE ticks, measured from the start-bit falling edge.
- TX_BUSY = (state!=IDLE) | (count!=0), registered.
- Reset mid-frame: UART_TX goes to 1 asynchronously and FIFO contents are discarded. The first frame after reset release begins at the first tick after a push.
- brclk stuck (no ticks): the FSM holds its state indefinitely, and UART_TX holds its last value.

Test Plan:
- Single byte:
  - Setup: sysclk 100 MHz, brclk from UART_Baud_Rate_Generator (9600 baud, bit 104166 ns); push 0x55.
  - Required: UART_TX = 0,1,0,1,0,1,0,1,0,1 at bit time 104166 ns ±1 tick. TX_BUSY falls after the stop bit; TX_STATUS stays 1.
- Back-to-back:
  - Stimulus: push 0x41, 0x42, 0x43 in consecutive sysclk cycles.
  - Required: three frames, and each start bit begins exactly at the prior stop-bit end (no gap). The bench UART_Receiver reports 0x41, 0x42, 0x43 in order.
- Overflow (DEPTH=4):
  - Stimulus: push 6 bytes 0x10..0x15 in consecutive cycles before the first tick.
  - Required: TX_STATUS=0 after the 4th push, TX_OVERRUN=1, and only 0x10..0x13 are transmitted.
- Push on tick cycle:
  - Stimulus: with the FIFO empty and IDLE, push 0xA5 in the exact tick cycle.
  - Required: the start bit begins on the following tick, not the current one. Frame content is 0xA5 LSB-first.
- Reset mid-frame:
  - Stimulus: assert reset during data bit 3 of 0xFF with 2 bytes queued.
  - Required: UART_TX=1 within the same cycle, TX_BUSY=0, count=0, TX_OVERRUN=0. No further frames appear until a new push.
- STOP_BITS=2, OVERSAMPLE=8:
  - Stimulus: push 0x00, 0xFF.
  - Required: each frame is 11*8 ticks. The stop-high period between frames is exactly 16 ticks.
